// File: rtl/multiplier.sv
// Unsigned shift-add multiplier, one multiplier bit per clock, with a packed BCD view of the product.
// Optional BCD converter is built only when MULTIPLIER_BCD_EN is defined; otherwise bcd is tied to zero.
module multiplier #(
    parameter int N = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N-1:0]                  a_in,
    input  logic [N-1:0]                  b_in,
    input  logic                          start,
    output logic [2*N-1:0]                out,
    output logic                          finish,
    output logic [4*(((2*N)/3)+1)-1:0]    bcd
);

    localparam int D  = ((2 * N) / 3) + 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [N-1:0]    a_reg;
    logic [N-1:0]    b_reg;
    logic [2*N-1:0]  acc;
    logic [CW-1:0]   count;
    logic [2*N-1:0]  partial;
    logic [2*N-1:0]  acc_next;

    // Partial product for the current multiplier bit, already aligned to its weight.
    always_comb begin
        partial  = b_reg[count] ? ({{N{1'b0}}, a_reg} << count) : '0;
        acc_next = acc + partial;
    end

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            out    <= '0;
            finish <= 1'b0;
            a_reg  <= '0;
            b_reg  <= '0;
            acc    <= '0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a_in;
                        b_reg <= b_in;
                        acc   <= '0;
                        count <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc   <= acc_next;
                    count <= count + CW'(1);
                    // Last bit: publish the completed sum directly so finish lands N edges after start.
                    if (count == LAST) begin
                        out    <= acc_next;
                        finish <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (!start) begin
                        finish <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    finish <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

`ifdef MULTIPLIER_BCD_EN
    logic [4*D-1:0] bcd_work;

    // Double-dabble: before each shift, any digit of 5 or more gets 3 added.
    always_comb begin
        bcd_work = '0;
        for (int i = 2 * N - 1; i >= 0; i--) begin
            for (int d = 0; d < D; d++) begin
                if (bcd_work[4*d +: 4] >= 4'd5) begin
                    bcd_work[4*d +: 4] = bcd_work[4*d +: 4] + 4'd3;
                end
            end
            bcd_work = {bcd_work[4*D-2:0], out[i]};
        end
    end

    assign bcd = bcd_work;
`else
    assign bcd = '0;
`endif

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier (N=5): directed and random products, handshake, latency and reset cases.
// Expected BCD follows MULTIPLIER_BCD_EN: decimal digits of the product when defined, zero otherwise.
module tb_multiplier;

    localparam int N = 5;
    localparam int D = ((2 * N) / 3) + 1;

    logic             clk;
    logic             reset;
    logic [N-1:0]     a_in;
    logic [N-1:0]     b_in;
    logic             start;
    logic [2*N-1:0]   out;
    logic             finish;
    logic [4*D-1:0]   bcd;

    int checks;
    int fails;
    logic [2*N-1:0] last_prod;

    multiplier #(.N(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .a_in   (a_in),
        .b_in   (b_in),
        .start  (start),
        .out    (out),
        .finish (finish),
        .bcd    (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference BCD: plain decimal digit extraction.
    function automatic logic [4*D-1:0] exp_bcd(input int value);
        logic [4*D-1:0] r;
        int v;
        r = '0;
        v = value;
`ifdef MULTIPLIER_BCD_EN
        for (int d = 0; d < D; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
`endif
        return r;
    endfunction

    // One full transaction from IDLE back to IDLE, with optional start hold and operand scrambling.
    task automatic do_mult(input logic [N-1:0] a, input logic [N-1:0] b,
                           input bit hold, input bit scramble, input string tag);
        int lat;
        int prod;
        logic [2*N-1:0] held_out;
        prod = int'(a) * int'(b);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        tick();
        checks++;
        if (finish !== 1'b0 || out !== last_prod) begin
            fails++;
            $display("FAIL %s busy_hold: finish=%0b out=%0d, required finish=0 out=%0d",
                     tag, finish, out, last_prod);
        end
        if (scramble) begin
            a_in = N'($urandom);
            b_in = N'($urandom);
        end
        lat = 0;
        while (finish !== 1'b1 && lat < 3 * N) begin
            tick();
            lat++;
            if (scramble) begin
                a_in = N'($urandom);
                b_in = N'($urandom);
            end
        end
        checks++;
        if (lat != N) begin
            fails++;
            $display("FAIL %s latency: got %0d edges, required %0d", tag, lat, N);
        end
        last_prod = (2*N)'(prod);
        checks++;
        if (out !== last_prod) begin
            fails++;
            $display("FAIL %s product: got %0d, required %0d", tag, out, last_prod);
        end
        checks++;
        if (bcd !== exp_bcd(prod)) begin
            fails++;
            $display("FAIL %s bcd: got %h, required %h", tag, bcd, exp_bcd(prod));
        end
        if (hold) begin
            held_out = out;
            a_in = N'($urandom);
            b_in = N'($urandom);
            for (int i = 0; i < 4; i++) begin
                tick();
                checks++;
                if (finish !== 1'b1 || out !== held_out) begin
                    fails++;
                    $display("FAIL %s done_hold: finish=%0b out=%0d, required finish=1 out=%0d",
                             tag, finish, out, held_out);
                end
            end
        end
        start = 1'b0;
        tick();
        checks++;
        if (finish !== 1'b0 || out !== last_prod) begin
            fails++;
            $display("FAIL %s return_idle: finish=%0b out=%0d, required finish=0 out=%0d",
                     tag, finish, out, last_prod);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        tick();
        tick();
        checks++;
        if (out !== '0 || finish !== 1'b0 || bcd !== '0) begin
            fails++;
            $display("FAIL reset: out=%0d finish=%0b bcd=%h, required 0 0 0", out, finish, bcd);
        end
        reset = 1'b0;
        last_prod = '0;
        tick();
        checks++;
        if (finish !== 1'b0 || out !== '0) begin
            fails++;
            $display("FAIL reset_idle: finish=%0b out=%0d, required 0 0", finish, out);
        end
    endtask

    task automatic test_directed();
        do_mult(5'd26, 5'd30, 1'b1, 1'b0, "d26x30");
        do_mult(5'd13, 5'd13, 1'b0, 1'b0, "d13x13");
        do_mult(5'd31, 5'd31, 1'b0, 1'b0, "d31x31");
        do_mult(5'd0,  5'd17, 1'b0, 1'b0, "d0x17");
        do_mult(5'd31, 5'd1,  1'b0, 1'b0, "d31x1");
    endtask

    task automatic test_start_hold();
        do_mult(5'd19, 5'd23, 1'b1, 1'b0, "hold19x23");
    endtask

    task automatic test_operand_change();
        do_mult(5'd29, 5'd27, 1'b0, 1'b1, "scramble29x27");
        do_mult(5'd17, 5'd11, 1'b1, 1'b1, "scramble17x11");
    endtask

    task automatic test_reset_mid_busy();
        int seen;
        a_in  = 5'd21;
        b_in  = 5'd25;
        start = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b1;
        start = 1'b0;
        tick();
        checks++;
        if (out !== '0 || finish !== 1'b0 || bcd !== '0) begin
            fails++;
            $display("FAIL mid_busy_reset: out=%0d finish=%0b bcd=%h, required 0 0 0", out, finish, bcd);
        end
        reset = 1'b0;
        last_prod = '0;
        seen = 0;
        for (int i = 0; i < N + 3; i++) begin
            tick();
            if (finish !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            fails++;
            $display("FAIL mid_busy_no_resume: finish high on %0d cycles, required 0", seen);
        end
        do_mult(5'd9, 5'd14, 1'b0, 1'b0, "after_reset9x14");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            do_mult(N'($urandom), N'($urandom), bit'($urandom_range(0, 1)),
                    bit'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_back_to_back();
        do_mult(5'd31, 5'd30, 1'b0, 1'b0, "b2b_a");
        do_mult(5'd2,  5'd3,  1'b0, 1'b0, "b2b_b");
        do_mult(5'd16, 5'd16, 1'b0, 1'b0, "b2b_c");
    endtask

    initial begin
        checks    = 0;
        fails     = 0;
        last_prod = '0;
        reset     = 1'b1;
        start     = 1'b0;
        a_in      = '0;
        b_in      = '0;
        test_reset();
        test_directed();
        test_start_hold();
        test_operand_change();
        test_reset_mid_busy();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
